// File: rtl/mips_pkg.sv
// mips_pkg: shared state encoding, vector defaults and next-PC source select for the fetch sequencer.
// Revision 1.0
`default_nettype none

package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_JR     = 3'd3,
        SEL_ERET   = 3'd4,
        SEL_HALT   = 3'd5,
        SEL_EXC    = 3'd6
    } npc_sel_e;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_mux.sv
// next_pc_mux: fixed-priority next-PC source select with word-alignment check on redirect targets.
// Revision 1.0
`default_nettype none

module next_pc_mux
    import mips_pkg::*;
(
    input  logic        exc,
    input  logic        halt_instr,
    input  logic        eret,
    input  logic        jr,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] pc_in,
    input  logic [31:0] epc,
    input  logic [31:0] jr_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] branch_target,
    output npc_sel_e    sel,
    output logic [31:0] target,
    output logic        addr_err
);

    always_comb begin
        sel      = SEL_SEQ;
        target   = pc_in + 32'd4;
        addr_err = 1'b0;
        if (exc) begin
            sel    = SEL_EXC;
            target = pc_in;
        end else if (halt_instr) begin
            sel    = SEL_HALT;
            target = pc_in;
        end else if (eret) begin
            sel      = SEL_ERET;
            target   = epc;
            addr_err = misaligned(epc);
        end else if (jr) begin
            sel      = SEL_JR;
            target   = jr_target;
            addr_err = misaligned(jr_target);
        end else if (jump) begin
            sel      = SEL_JUMP;
            target   = jump_target;
            addr_err = misaligned(jump_target);
        end else if (branch_taken) begin
            sel      = SEL_BRANCH;
            target   = branch_target;
            addr_err = misaligned(branch_target);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch/execute FSM driving PC.next_pc, with fetch timeout, exception entry/return and halt.
// Revision 1.0
`default_nettype none

module pc_fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          TO_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        eret,
    input  logic        halt_instr,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic        instr_valid,
    output logic        commit,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        halted
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    logic [1:0]      state, state_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic [31:0]     epc_nxt;
    logic            in_handler_nxt;
    logic [31:0]     npc;
    logic            req, ivalid, cmt, take_exc;

    npc_sel_e        sel;
    logic [31:0]     mux_target;
    logic            addr_err;

    next_pc_mux u_next_pc_mux (
        .exc           (exc),
        .halt_instr    (halt_instr),
        .eret          (eret),
        .jr            (jr),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .pc_in         (pc_in),
        .epc           (epc),
        .jr_target     (jr_target),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .sel           (sel),
        .target        (mux_target),
        .addr_err      (addr_err)
    );

    always_comb begin
        state_nxt      = state;
        to_cnt_nxt     = to_cnt;
        epc_nxt        = epc;
        in_handler_nxt = in_handler;
        npc            = pc_in;
        req            = 1'b0;
        ivalid         = 1'b0;
        cmt            = 1'b0;
        take_exc       = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                req = 1'b1;
                if (imem_ready) begin
                    state_nxt  = ST_EXEC;
                    to_cnt_nxt = '0;
                end else if (to_cnt == TO_LAST) begin
                    take_exc   = 1'b1;
                    to_cnt_nxt = '0;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            ST_EXEC: begin
                ivalid = 1'b1;
                cmt    = ~stall;
                // A stalled instruction is re-evaluated in full once the stall drops.
                if (!stall) begin
                    state_nxt = ST_FETCH;
                    if (sel == SEL_EXC || addr_err || (sel == SEL_ERET && !in_handler)) begin
                        take_exc = 1'b1;
                    end else if (sel == SEL_HALT) begin
                        state_nxt = ST_HALT;
                    end else begin
                        npc = mux_target;
                        if (sel == SEL_ERET) in_handler_nxt = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if (take_exc) begin
            if (in_handler) begin
                state_nxt = ST_HALT;
                npc       = pc_in;
            end else begin
                epc_nxt        = pc_in;
                in_handler_nxt = 1'b1;
                npc            = EXC_VECTOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            to_cnt     <= '0;
            epc        <= '0;
            in_handler <= 1'b0;
        end else begin
            state      <= state_nxt;
            to_cnt     <= to_cnt_nxt;
            epc        <= epc_nxt;
            in_handler <= in_handler_nxt;
        end
    end

    assign next_pc     = reset ? RESET_VECTOR : npc;
    assign imem_req    = ~reset & req;
    assign instr_valid = ~reset & ivalid;
    assign commit      = ~reset & cmt;
    assign halted      = (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed stimulus with a commit-driven scoreboard for pc_fetch_sequencer.
// Revision 1.0
`default_nettype none

module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        imem_ready = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        exc = 1'b0;
    logic        eret = 1'b0;
    logic        halt_instr = 1'b0;
    logic [31:0] next_pc;
    logic        imem_req, instr_valid, commit, in_handler, halted;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] npc;
        logic [31:0] epc;
        logic        inh;
        logic        hlt;
    } exp_t;
    exp_t q[$];

    pc_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .exc           (exc),
        .eret          (eret),
        .halt_instr    (halt_instr),
        .next_pc       (next_pc),
        .imem_req      (imem_req),
        .instr_valid   (instr_valid),
        .commit        (commit),
        .epc           (epc),
        .in_handler    (in_handler),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // PC register in the surrounding datapath.
    always @(posedge clk) pc <= next_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_ctl();
        stall = 0; branch_taken = 0; jump = 0; jr = 0; exc = 0; eret = 0; halt_instr = 0;
    endtask

    task automatic wait_exec();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_exec: instr_valid not seen within 40 cycles");
        end
    endtask

    task automatic do_exec(input string name, input logic [31:0] npc, input logic [31:0] e,
                           input logic inh, input logic hlt);
        exp_t r;
        r.name = name; r.npc = npc; r.epc = e; r.inh = inh; r.hlt = hlt;
        q.push_back(r);
        wait_exec();
        @(posedge clk) #1;
        clr_ctl();
    endtask

    // Monitor: each retiring instruction is checked for its next_pc, then the state it leaves behind.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && commit) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got commit with next_pc %h, expected none", next_pc);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_npc"}, next_pc, e.npc);
                    @(negedge clk);
                    chk({e.name, "_epc"}, epc, e.epc);
                    chk({e.name, "_inh"}, {31'b0, in_handler}, {31'b0, e.inh});
                    chk({e.name, "_halted"}, {31'b0, halted}, {31'b0, e.hlt});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        clr_ctl();
        @(negedge clk);
        chk("rst_npc0", next_pc, 32'h0);
        chk("rst_req0", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        chk("rst_npc1", next_pc, 32'h0);
        chk("rst_commit", {31'b0, commit}, 32'h0);
        @(posedge clk) #1 reset = 0;
        @(negedge clk);
        chk("idle_req", {31'b0, imem_req}, 32'h0);

        do_exec("seq0", 32'h4, 32'h0, 0, 0);
        do_exec("seq1", 32'h8, 32'h0, 0, 0);
        do_exec("seq2", 32'hC, 32'h0, 0, 0);
        do_exec("seq3", 32'h10, 32'h0, 0, 0);

        stall = 1; branch_taken = 1; branch_target = 32'h20; jump = 1; jump_target = 32'h40;
        wait_exec();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_npc", next_pc, 32'h10);
            chk("stall_commit", {31'b0, commit}, 32'h0);
        end
        @(posedge clk) #1 stall = 0;
        do_exec("jump_over_branch", 32'h40, 32'h0, 0, 0);

        jump = 1; jump_target = 32'h24;
        do_exec("jump24", 32'h24, 32'h0, 0, 0);
        exc = 1;
        do_exec("exc", 32'h80, 32'h24, 1, 0);
        eret = 1;
        do_exec("eret", 32'h24, 32'h24, 0, 0);
        do_exec("seq28", 32'h28, 32'h24, 0, 0);
        do_exec("seq2c", 32'h2C, 32'h24, 0, 0);
        do_exec("seq30", 32'h30, 32'h24, 0, 0);
        jr = 1; jr_target = 32'h102;
        do_exec("jr_misalign", 32'h80, 32'h30, 1, 0);
        exc = 1;
        do_exec("double_fault", 32'h80, 32'h30, 1, 1);
        repeat (3) begin
            @(negedge clk);
            chk("halt_npc", next_pc, 32'h80);
            chk("halt_req", {31'b0, imem_req}, 32'h0);
            chk("halt_ivalid", {31'b0, instr_valid}, 32'h0);
            chk("halt_flag", {31'b0, halted}, 32'h1);
        end

        @(posedge clk) #1 reset = 1;
        @(negedge clk);
        chk("rst_halt_npc", next_pc, 32'h0);
        chk("rst_halt_req", {31'b0, imem_req}, 32'h0);
        @(posedge clk) #1 reset = 0;
        @(negedge clk);
        chk("rst_halt_halted", {31'b0, halted}, 32'h0);
        chk("rst_halt_epc", epc, 32'h0);
        chk("rst_halt_inh", {31'b0, in_handler}, 32'h0);

        do_exec("seq4b", 32'h4, 32'h0, 0, 0);
        do_exec("seq8b", 32'h8, 32'h0, 0, 0);
        imem_ready = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) chk("to_wait_npc", next_pc, 32'h8);
            else chk("to_fire_npc", next_pc, 32'h80);
        end
        @(posedge clk) #1 imem_ready = 1;
        @(negedge clk);
        chk("to_epc", epc, 32'h8);
        chk("to_inh", {31'b0, in_handler}, 32'h1);
        chk("to_refetch_req", {31'b0, imem_req}, 32'h1);
        eret = 1;
        do_exec("eret_to", 32'h8, 32'h8, 0, 0);

        imem_ready = 0;
        repeat (5) @(negedge clk);
        @(posedge clk) #1 reset = 1;
        @(negedge clk);
        chk("rst_fetch_npc", next_pc, 32'h0);
        chk("rst_fetch_req", {31'b0, imem_req}, 32'h0);
        @(posedge clk) #1 reset = 0;
        @(negedge clk);
        chk("rst_fetch_epc", epc, 32'h0);
        chk("rst_fetch_inh", {31'b0, in_handler}, 32'h0);
        chk("rst_fetch_halted", {31'b0, halted}, 32'h0);
        chk("rst_fetch_idle_req", {31'b0, imem_req}, 32'h0);
        @(posedge clk) #1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("to_cleared_npc", next_pc, 32'h0);
        end
        @(posedge clk) #1 imem_ready = 1;

        jump = 1; jump_target = 32'hFFFF_FFFC;
        do_exec("jump_top", 32'hFFFF_FFFC, 32'h0, 0, 0);
        do_exec("wrap", 32'h0, 32'h0, 0, 0);
        do_exec("seq4c", 32'h4, 32'h0, 0, 0);
        branch_taken = 1; branch_target = 32'h42;
        do_exec("br_misalign", 32'h80, 32'h4, 1, 0);
        halt_instr = 1; eret = 1;
        do_exec("halt_pri", 32'h80, 32'h4, 1, 1);

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Control block that drives the `next_pc` input of the `PC` register and sequences instruction fetch against a handshaked instruction memory.
- Selects the next PC from sequential, branch, jump, `jr`, exception, and return (`eret`) sources, with fixed priority.
- Adds stall, halt, fetch-timeout and double-fault handling around the single-cycle datapath.
- Sits between control unit / ALU branch logic and `PC`; `pc` output of `PC` feeds back as `pc_in`.

Parameters:
- `RESET_VECTOR`, 32'h0000_0000, `next_pc` driven while `reset` is high.
- `EXC_VECTOR`, 32'h0000_0080, handler entry address.
- `FETCH_TIMEOUT`, 16, max cycles in FETCH without `imem_ready` before bus-error exception.
- `TO_W`, 5, timeout counter width; must satisfy 2^`TO_W` > `FETCH_TIMEOUT`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `pc_in`  in  32  current PC from `PC` register.
- `imem_ready`  in  1  instruction memory data valid this cycle.
- `stall`  in  1  datapath hold request.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  `j`/`jal` decoded.
- `jump_target`  in  32  jump destination.
- `jr`  in  1  `jr` decoded.
- `jr_target`  in  32  register destination.
- `exc`  in  1  external/datapath exception (overflow, illegal opcode).
- `eret`  in  1  return from handler.
- `halt_instr`  in  1  halt/`syscall`-exit decoded.
- `next_pc`  out  32  to `PC.next_pc`.
- `imem_req`  out  1  fetch request.
- `instr_valid`  out  1  instruction available to datapath (EXEC state).
- `commit`  out  1  instruction retires this cycle; write enables gated by it.
- `epc`  out  32  saved exception PC.
- `in_handler`  out  1  executing exception handler.
- `halted`  out  1  core stopped.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- All transitions are on the `clk` rising edge.
- Reset (any state, including mid-fetch):
  - State goes to IDLE; timeout counter, `epc`, `in_handler` and `halted` clear to 0.
  - While `reset` is high, `next_pc`=`RESET_VECTOR`, and `imem_req`, `instr_valid` and `commit` are 0.
- `next_pc` equals `pc_in` (hold) in IDLE, FETCH, HALT, and in EXEC with `stall`=1.
- IDLE: one cycle, then FETCH.
- FETCH:
  - `imem_req`=1. `imem_ready`=1 moves to EXEC and clears the counter.
  - Otherwise the counter increments. Counter reaching `FETCH_TIMEOUT` triggers the exception path (below) and returns to FETCH.
- EXEC:
  - `instr_valid`=1, `commit`=`~stall`.
  - `stall`=1: remain in EXEC, hold PC.
  - Else next state is FETCH, except the halt and double-fault cases below, which go to HALT. `next_pc` is chosen by priority:
    1. `exc` → exception path.
    2. `halt_instr` → HALT, `next_pc`=`pc_in`.
    3. `eret` → `epc`, clears `in_handler` (`eret` outside handler = illegal, exception path).
    4. `jr` → `jr_target`.
    5. `jump` → `jump_target`.
    6. `branch_taken` → `branch_target`.
    7. Default → `pc_in`+4, 32-bit modulo; 0xFFFF_FFFC wraps to 0.
  - A selected target (`jr`/`jump`/`branch`/`eret`) with bits[1:0]≠0 is an address-error exception instead. `commit` stays 1 for the faulting branch (no register write side effects are expected).
- Exception path (`exc`, timeout, misaligned, illegal `eret`):
  - If `in_handler`=0: `epc`<=`pc_in`, `in_handler`<=1, `next_pc`=`EXC_VECTOR`.
  - If `in_handler`=1 (double fault): HALT, `next_pc`=`pc_in`, `epc` unchanged.
- HALT: `halted`=1, all requests 0; exits only on `reset`.
- Simultaneous `exc` with `stall`: `stall` wins; the exception is re-evaluated when the stall drops.
- Stall is ignored in FETCH.

Decomposition:
- Shared package `mips_pkg`: state enum (IDLE/FETCH/EXEC/HALT), `RESET_VECTOR`/`EXC_VECTOR` defaults, next-PC source select encoding.
- Sub-module `next_pc_mux`: combinational priority select plus alignment check, returning target and `addr_err`. The FSM, timeout counter and `epc`/`in_handler` registers stay in the top module.

Test Plan:
1. Reset high 2 cycles, then `imem_ready`=1 every FETCH → `next_pc`=0 during reset; PC sequence 0,4,8,C with one commit per FETCH+EXEC pair.
2. At `pc`=0x10 in EXEC, `branch_taken`=1 and `jump`=1 (`jump_target`=0x40, `branch_target`=0x20) → `next_pc`=0x40; with `stall` held 3 cycles first → `next_pc`=0x10 and `commit`=0 for those cycles.
3. `exc` at `pc`=0x24 → `epc`=0x24, `next_pc`=0x80, `in_handler`=1; later `eret` → `next_pc`=0x24, `in_handler`=0.
4. `jr_target`=0x102 at `pc`=0x30 → address error: `epc`=0x30, `next_pc`=0x80. A second `exc` inside the handler → `halted`=1, PC frozen.
5. `imem_ready` held 0 for 16 cycles at `pc`=0x8 → exception with `epc`=0x8. Separately, `pc_in`=0xFFFF_FFFC default path → `next_pc`=0.
6. Assert `reset` during FETCH wait and during HALT → IDLE next cycle, `halted`=0, `epc`=0, `next_pc`=`RESET_VECTOR`.
